// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared constants, round-robin helper and response-pipe record for bram_port_arbiter
package bram_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ABITS_DEF   = 11;
    localparam int DBITS_DEF   = 32;

    // The pipe record is sized for the largest supported build; narrower builds use the low bits.
    localparam int NUM_REQ_MAX = 8;
    localparam int DBITS_MAX   = 128;
    localparam int BEBITS_MAX  = DBITS_MAX / 8;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [NUM_REQ_MAX-1:0] id;
        logic                   fwd_hit;
        logic [BEBITS_MAX-1:0]  fwd_be;
        logic [DBITS_MAX-1:0]   fwd_data;
    } rsp_pipe_t;

endpackage

// File: rtl/bram_rr_arbiter.sv
// rtl/bram_rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves just past each winner
module bram_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = NUM_REQ_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;
    logic [PW:0]   idx;

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        win       = ptr_q;
        idx       = '0;
        // Scan from the farthest offset inward so the candidate nearest ptr_q is the one kept.
        for (int i = N - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (req[idx[PW-1:0]]) begin
                win       = idx[PW-1:0];
                gnt_valid = 1'b1;
            end
        end
        if (gnt_valid) begin
            gnt[win] = 1'b1;
        end
        ptr_d = gnt_valid ? PW'(rr_next(int'(win), N)) : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares one BRAM read port and one byte-enabled write port among NUM_REQ requesters; BRAM_ARB_OUTREG_EN adds an output register (T+2 latency)
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ABITS   = ABITS_DEF,
    parameter int DBITS   = DBITS_DEF,
    parameter int BEBITS  = DBITS / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ABITS-1:0]  req_addr_i,
    input  logic [NUM_REQ*DBITS-1:0]  req_wdata_i,
    input  logic [NUM_REQ*BEBITS-1:0] req_be_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DBITS-1:0]          rsp_data_o,
    output logic                      rd_en_o,
    output logic [ABITS-1:0]          rd_addr_o,
    input  logic [DBITS-1:0]          rd_data_i,
    output logic [BEBITS-1:0]         wr_en_o,
    output logic [ABITS-1:0]          wr_addr_o,
    output logic [DBITS-1:0]          wr_data_o
);

    logic [NUM_REQ-1:0] rd_req;
    logic [NUM_REQ-1:0] wr_req;
    logic [NUM_REQ-1:0] rd_gnt;
    logic [NUM_REQ-1:0] wr_gnt;
    logic               rd_any;
    logic               wr_any;
    logic [ABITS-1:0]   rd_addr;
    logic [ABITS-1:0]   wr_addr;
    logic [DBITS-1:0]   wr_data;
    logic [BEBITS-1:0]  wr_be;
    logic               rd_fire;
    logic               wr_fire;
    logic               fwd_hit;

    assign rd_req = req_valid_i & ~req_we_i;
    assign wr_req = req_valid_i & req_we_i;

    bram_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rd_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req       (rd_req),
        .gnt       (rd_gnt),
        .gnt_valid (rd_any)
    );

    bram_rr_arbiter #(
        .N (NUM_REQ)
    ) u_wr_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req       (wr_req),
        .gnt       (wr_gnt),
        .gnt_valid (wr_any)
    );

    // Grants are one-hot, so an OR-reduction acts as the winner mux.
    always_comb begin
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (rd_gnt[k]) begin
                rd_addr = rd_addr | req_addr_i[k*ABITS +: ABITS];
            end
            if (wr_gnt[k]) begin
                wr_addr = wr_addr | req_addr_i[k*ABITS +: ABITS];
                wr_data = wr_data | req_wdata_i[k*DBITS +: DBITS];
                wr_be   = wr_be | req_be_i[k*BEBITS +: BEBITS];
            end
        end
    end

    assign rd_fire = rst_ni & rd_any;
    assign wr_fire = rst_ni & wr_any;
    assign fwd_hit = rd_fire & wr_fire & (rd_addr == wr_addr);

    assign req_ready_o = rst_ni ? (rd_gnt | wr_gnt) : '0;
    assign rd_en_o     = rd_fire;
    assign rd_addr_o   = rd_addr;
    assign wr_en_o     = wr_fire ? wr_be : '0;
    assign wr_addr_o   = wr_addr;
    assign wr_data_o   = wr_data;

    rsp_pipe_t pipe_d;
    rsp_pipe_t pipe_q;

    always_comb begin
        pipe_d                     = '0;
        pipe_d.valid               = rd_fire;
        pipe_d.id[NUM_REQ-1:0]     = rd_gnt;
        pipe_d.fwd_hit             = fwd_hit;
        pipe_d.fwd_be[BEBITS-1:0]  = fwd_hit ? wr_be : '0;
        pipe_d.fwd_data[DBITS-1:0] = fwd_hit ? wr_data : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // The BRAM returns pre-write data on a same-address collision; patch in the written bytes.
    logic [DBITS-1:0] merged;

    always_comb begin
        merged = rd_data_i;
        for (int i = 0; i < BEBITS; i++) begin
            if (pipe_q.fwd_hit && pipe_q.fwd_be[i]) begin
                merged[i*8 +: 8] = pipe_q.fwd_data[i*8 +: 8];
            end
        end
    end

    logic [NUM_REQ-1:0] stb_d;
    logic [DBITS-1:0]   data_d;
    logic [DBITS-1:0]   data_q;

    assign stb_d  = pipe_q.valid ? pipe_q.id[NUM_REQ-1:0] : '0;
    assign data_d = pipe_q.valid ? merged : data_q;

`ifdef BRAM_ARB_OUTREG_EN
    logic [NUM_REQ-1:0] stb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stb_q  <= '0;
            data_q <= '0;
        end else begin
            stb_q  <= stb_d;
            data_q <= data_d;
        end
    end

    assign rsp_valid_o = stb_q;
    assign rsp_data_o  = data_q;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rsp_valid_o = stb_d;
    assign rsp_data_o  = data_d;
`endif

    logic unused_pipe_bits;
    assign unused_pipe_bits = ^pipe_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - self-checking bench for bram_port_arbiter with BRAM emulator and reference model
module tb_bram_port_arbiter;

    localparam int NR = 4;
    localparam int AB = 11;
    localparam int DB = 32;
    localparam int BB = DB / 8;
`ifdef BRAM_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    v;
    logic [NR-1:0]    we;
    logic [NR*AB-1:0] addr;
    logic [NR*DB-1:0] wd;
    logic [NR*BB-1:0] be;
    logic [NR-1:0]    req_ready_o;
    logic [NR-1:0]    rsp_valid_o;
    logic [DB-1:0]    rsp_data_o;
    logic             rd_en_o;
    logic [AB-1:0]    rd_addr_o;
    logic [DB-1:0]    rd_data;
    logic [BB-1:0]    wr_en_o;
    logic [AB-1:0]    wr_addr_o;
    logic [DB-1:0]    wr_data_o;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .NUM_REQ (NR),
        .ABITS   (AB),
        .DBITS   (DB)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (v),
        .req_we_i    (we),
        .req_addr_i  (addr),
        .req_wdata_i (wd),
        .req_be_i    (be),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o)
    );

    function automatic logic [DB-1:0] init_val(input int a);
        if (a == 'h010) return 32'hDEADBEEF;
        if (a == 'h020) return 32'h11223344;
        return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    // BRAM emulator: read-first, one cycle read latency, byte write enables
    logic [DB-1:0] bram [int];

    always @(posedge clk) begin : emu
        logic [DB-1:0] w;
        if (rd_en_o) begin
            rd_data <= bram.exists(int'(rd_addr_o)) ? bram[int'(rd_addr_o)] : init_val(int'(rd_addr_o));
        end
        if (wr_en_o != '0) begin
            w = bram.exists(int'(wr_addr_o)) ? bram[int'(wr_addr_o)] : init_val(int'(wr_addr_o));
            for (int b = 0; b < BB; b++) begin
                if (wr_en_o[b]) w[8*b +: 8] = wr_data_o[8*b +: 8];
            end
            bram[int'(wr_addr_o)] = w;
        end
    end

    // Reference model state
    typedef struct {
        int            due;
        int            id;
        logic [DB-1:0] data;
    } rsp_t;

    rsp_t          rsp_q[$];
    logic [DB-1:0] ref_mem [int];
    int            rd_ptr;
    int            wr_ptr;
    logic [DB-1:0] last_data;
    int            cyc;
    int            checks;
    int            errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input int ptr, input logic [NR-1:0] cand);
        for (int i = 0; i < NR; i++) begin
            if (cand[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [DB-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic model_reset();
        rsp_q.delete();
        rd_ptr    = 0;
        wr_ptr    = 0;
        last_data = '0;
    endtask

    task automatic eval();
        rsp_t          e;
        int            rw;
        int            ww;
        int            a;
        logic [NR-1:0] erdy;
        logic [NR-1:0] ev;
        logic [DB-1:0] ed;
        logic [DB-1:0] word;
        #1;
        if (!rst_n) begin
            chk("rst_ready", 64'(req_ready_o), 64'(0));
            chk("rst_rd_en", 64'(rd_en_o), 64'(0));
            chk("rst_wr_en", 64'(wr_en_o), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
            chk("rst_rsp_data", 64'(rsp_data_o), 64'(0));
            model_reset();
            return;
        end
        ev = '0;
        ed = last_data;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            e         = rsp_q.pop_front();
            ev        = NR'(1 << e.id);
            ed        = e.data;
            last_data = e.data;
        end
        chk("rsp_valid", 64'(rsp_valid_o), 64'(ev));
        chk("rsp_data", 64'(rsp_data_o), 64'(ed));

        rw   = pick(rd_ptr, v & ~we);
        ww   = pick(wr_ptr, v & we);
        erdy = '0;
        if (rw >= 0) erdy[rw] = 1'b1;
        if (ww >= 0) erdy[ww] = 1'b1;
        chk("ready", 64'(req_ready_o), 64'(erdy));
        chk("rd_en", 64'(rd_en_o), 64'(rw >= 0));
        if (rw >= 0) chk("rd_addr", 64'(rd_addr_o), 64'(addr[rw*AB +: AB]));
        if (ww >= 0) begin
            chk("wr_en", 64'(wr_en_o), 64'(be[ww*BB +: BB]));
            chk("wr_addr", 64'(wr_addr_o), 64'(addr[ww*AB +: AB]));
            chk("wr_data", 64'(wr_data_o), 64'(wd[ww*DB +: DB]));
        end else begin
            chk("wr_en_idle", 64'(wr_en_o), 64'(0));
        end

        // Commit the write first so a same-cycle read observes it.
        if (ww >= 0) begin
            a    = int'(addr[ww*AB +: AB]);
            word = ref_rd(a);
            for (int b = 0; b < BB; b++) begin
                if (be[ww*BB + b]) word[8*b +: 8] = wd[ww*DB + 8*b +: 8];
            end
            ref_mem[a] = word;
            wr_ptr     = (ww + 1) % NR;
        end
        if (rw >= 0) begin
            e.due  = cyc + LAT;
            e.id   = rw;
            e.data = ref_rd(int'(addr[rw*AB +: AB]));
            rsp_q.push_back(e);
            rd_ptr = (rw + 1) % NR;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        v  = '0;
        we = '0;
        for (int i = 0; i < n; i++) begin
            eval();
            tick();
        end
    endtask

    typedef struct {
        logic [NR-1:0]    v;
        logic [NR-1:0]    we;
        logic [NR*AB-1:0] addr;
        logic [NR*DB-1:0] wd;
        logic [NR*BB-1:0] be;
        logic [NR-1:0]    e_rdy;
        logic             e_rd_en;
        logic [AB-1:0]    e_rd_addr;
        logic [BB-1:0]    e_wr_en;
        logic             e_wgnt;
        logic [AB-1:0]    e_wr_addr;
        logic [DB-1:0]    e_wr_data;
        logic [NR-1:0]    e_rsp_v;
        logic [DB-1:0]    e_rsp_d;
    } vec_t;

    function automatic vec_t mkv(
        input logic [NR-1:0] v_, input logic [NR-1:0] we_, input logic [NR*AB-1:0] a_,
        input logic [NR*DB-1:0] d_, input logic [NR*BB-1:0] b_, input logic [NR-1:0] rdy,
        input logic rde, input logic [AB-1:0] rda, input logic [BB-1:0] wre, input logic wg,
        input logic [AB-1:0] wra, input logic [DB-1:0] wrd, input logic [NR-1:0] rv,
        input logic [DB-1:0] rd);
        vec_t t;
        t.v = v_; t.we = we_; t.addr = a_; t.wd = d_; t.be = b_;
        t.e_rdy = rdy; t.e_rd_en = rde; t.e_rd_addr = rda; t.e_wr_en = wre;
        t.e_wgnt = wg; t.e_wr_addr = wra; t.e_wr_data = wrd; t.e_rsp_v = rv; t.e_rsp_d = rd;
        return t;
    endfunction

    vec_t tbl [13];

    initial begin
        rst_n  = 1'b1;
        v      = '0;
        we     = '0;
        addr   = '0;
        wd     = '0;
        be     = '0;
        cyc    = 0;
        checks = 0;
        errors = 0;
        model_reset();
        #1 rst_n = 1'b0;

        tbl[0]  = mkv(4'b0001, 4'b0000, {11'h0, 11'h0, 11'h0, 11'h010}, '0, '0,
                      4'b0001, 1'b1, 11'h010, 4'h0, 1'b0, 11'h0, 32'h0, 4'b0001, 32'hDEADBEEF);
        tbl[1]  = mkv('0, '0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        tbl[2]  = mkv(4'b0110, 4'b0010, {11'h0, 11'h020, 11'h020, 11'h0},
                      {32'h0, 32'h0, 32'h00AABB00, 32'h0}, {4'h0, 4'h0, 4'h6, 4'h0},
                      4'b0110, 1'b1, 11'h020, 4'h6, 1'b1, 11'h020, 32'h00AABB00, 4'b0100, 32'h11AABB44);
        tbl[3]  = mkv(4'b1001, 4'b0001, {11'h030, 11'h0, 11'h0, 11'h040},
                      {96'h0, 32'h12345678}, {12'h0, 4'hF},
                      4'b1001, 1'b1, 11'h030, 4'hF, 1'b1, 11'h040, 32'h12345678, 4'b1000, init_val('h030));
        for (int j = 0; j < 5; j++) begin
            tbl[4+j] = mkv(4'b1111, 4'b0000, {11'h103, 11'h102, 11'h101, 11'h100}, '0, '0,
                           4'(1 << (j % 4)), 1'b1, 11'(32'h100 + j % 4), 4'h0, 1'b0, 11'h0, 32'h0,
                           4'(1 << (j % 4)), init_val('h100 + j % 4));
        end
        tbl[9]  = mkv(4'b0010, 4'b0010, {11'h0, 11'h0, 11'h050, 11'h0},
                      {32'h0, 32'h0, 32'hCAFEF00D, 32'h0}, '0,
                      4'b0010, 1'b0, 11'h0, 4'h0, 1'b1, 11'h050, 32'hCAFEF00D, '0, '0);
        tbl[10] = mkv(4'b0100, 4'b0000, {11'h0, 11'h020, 11'h0, 11'h0}, '0, '0,
                      4'b0100, 1'b1, 11'h020, 4'h0, 1'b0, 11'h0, 32'h0, 4'b0100, 32'h11AABB44);
        tbl[11] = tbl[1];
        tbl[12] = tbl[1];

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            eval();
            tick();
        end
        rst_n = 1'b1;

        // Directed table
        for (int r = 0; r < 13; r++) begin
            v = tbl[r].v; we = tbl[r].we; addr = tbl[r].addr; wd = tbl[r].wd; be = tbl[r].be;
            eval();
            chk("tbl_ready", 64'(req_ready_o), 64'(tbl[r].e_rdy));
            chk("tbl_rd_en", 64'(rd_en_o), 64'(tbl[r].e_rd_en));
            if (tbl[r].e_rd_en) chk("tbl_rd_addr", 64'(rd_addr_o), 64'(tbl[r].e_rd_addr));
            chk("tbl_wr_en", 64'(wr_en_o), 64'(tbl[r].e_wr_en));
            if (tbl[r].e_wgnt) begin
                chk("tbl_wr_addr", 64'(wr_addr_o), 64'(tbl[r].e_wr_addr));
                chk("tbl_wr_data", 64'(wr_data_o), 64'(tbl[r].e_wr_data));
            end
            if (r >= LAT) begin
                chk("tbl_rsp_valid", 64'(rsp_valid_o), 64'(tbl[r-LAT].e_rsp_v));
                if (tbl[r-LAT].e_rsp_v != '0) chk("tbl_rsp_data", 64'(rsp_data_o), 64'(tbl[r-LAT].e_rsp_d));
            end
            tick();
        end

        // Reset right behind a read grant: the response must never appear
        v = 4'b0010; we = '0; addr = {11'h0, 11'h0, 11'h060, 11'h0};
        eval();
        chk("pre_rst_gnt", 64'(req_ready_o), 64'(4'b0010));
        #1 rst_n = 1'b0;
        model_reset();
        tick();
        for (int i = 0; i < 2; i++) begin
            eval();
            tick();
        end
        rst_n = 1'b1;
        idle(LAT + 1);
        v = 4'b1111; we = '0; addr = {11'h013, 11'h012, 11'h011, 11'h010};
        eval();
        chk("post_rst_first_gnt", 64'(req_ready_o), 64'(4'b0001));
        tick();
        idle(LAT + 1);

        // Lone requester is granted every cycle and leaves the pointer just past itself
        v = 4'b0100; we = '0; addr = {11'h0, 11'h077, 11'h0, 11'h0};
        for (int i = 0; i < 10; i++) begin
            eval();
            chk("solo_gnt", 64'(req_ready_o), 64'(4'b0100));
            tick();
        end
        v = 4'b1111; we = '0;
        eval();
        chk("ptr_after_solo", 64'(req_ready_o), 64'(4'b1000));
        tick();
        idle(LAT + 1);

        // Random traffic on a small address window to provoke collisions
        for (int n = 0; n < 600; n++) begin
            v  = NR'($urandom);
            we = NR'($urandom);
            for (int k = 0; k < NR; k++) begin
                addr[k*AB +: AB] = AB'(32'h200 + $urandom_range(0, 7));
                wd[k*DB +: DB]   = DB'($urandom);
                be[k*BB +: BB]   = BB'($urandom);
            end
            eval();
            tick();
        end
        idle(LAT + 2);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
